// File: rtl/npc_rf_pkg.sv
// Shared types and helpers for the NPC general-purpose register file.
package npc_rf_pkg;

    // Write-back source selector encoding.
    typedef enum logic [1:0] {
        WSEL_ALU = 2'd0,
        WSEL_PC4 = 2'd1,
        WSEL_MEM = 2'd2,
        WSEL_CSR = 2'd3
    } wsel_e;

    // Link address offset for jump-and-link write-back.
    localparam int PC_STEP = 4;

    // Low bit of element 'idx' in a packed vector of 'width'-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a running count.
module rf_scoreboard
    import npc_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic [ADDR_WIDTH-1:0]   issue_rd,
    input  logic                    wen,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    output logic [(1<<ADDR_WIDTH)-1:0] busy,
    output logic [ADDR_WIDTH:0]     busy_count
);

    localparam int NREGS = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_next;
    logic [CW-1:0]    r_count;
    logic             w_set;
    logic             w_inc;
    logic             w_dec;

    // Next busy vector: clear on retire, then set on issue so a new producer wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_busy_next = r_busy;
        w_set = issue_valid && !((ZERO_REG != 0) && (issue_rd == '0));
        if (wen) begin
            w_busy_next[waddr] = 1'b0;
        end
        if (w_set) begin
            w_busy_next[issue_rd] = 1'b1;
        end
        // Count moves only when a bit actually flips.
        w_inc = w_set && !r_busy[issue_rd];
        w_dec = wen && r_busy[waddr] && !(w_set && (issue_rd == waddr));
    end

    // Busy bits and their popcount, kept in step on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            r_busy <= w_busy_next;
            if (w_inc && !w_dec) begin
                r_count <= r_count + CW'(1);
            end else if (w_dec && !w_inc) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign busy       = r_busy;
    assign busy_count = r_count;

endmodule

// File: rtl/gpr_file_sb.sv
// Multi-read-port register file with write-back source select and RAW scoreboard.
module gpr_file_sb
    import npc_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_READ    = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wen,
    input  logic [ADDR_WIDTH-1:0]           waddr,
    input  logic [1:0]                      wsel,
    input  logic [DATA_WIDTH-1:0]           pc,
    input  logic [DATA_WIDTH-1:0]           alu_data,
    input  logic [DATA_WIDTH-1:0]           mem_data,
    input  logic [DATA_WIDTH-1:0]           csr_data,
    input  logic [NR_READ*ADDR_WIDTH-1:0]   raddr,
    output logic [NR_READ*DATA_WIDTH-1:0]   rdata,
    output logic [NR_READ-1:0]              rbusy,
    input  logic                            issue_valid,
    input  logic [ADDR_WIDTH-1:0]           issue_rd,
    output logic [ADDR_WIDTH:0]             busy_count
);

    localparam int NREGS = 1 << ADDR_WIDTH;

    if ((NR_READ < 1) || (NR_READ > 4)) begin : g_bad_nr_read
        $error("gpr_file_sb: NR_READ must be in 1..4");
    end

    logic [DATA_WIDTH-1:0] r_rf [NREGS];
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_we;
    logic [NREGS-1:0]      w_busy;

    // Write-back data source; PC+4 wraps at DATA_WIDTH.
    always_comb begin
        w_wdata = alu_data;
        unique case (wsel_e'(wsel))
            WSEL_ALU: w_wdata = alu_data;
            WSEL_PC4: w_wdata = pc + DATA_WIDTH'(PC_STEP);
            WSEL_MEM: w_wdata = mem_data;
            WSEL_CSR: w_wdata = csr_data;
        endcase
    end

    assign w_we = wen && !((ZERO_REG != 0) && (waddr == '0));

    // Register array; reset clears every entry so reads are defined after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: clearing the whole array on reset forces flops rather than RAM; intended here.
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_we) begin
            r_rf[waddr] <= w_wdata;
        end
    end

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wen         (wen),
        .waddr       (waddr),
        .busy        (w_busy),
        .busy_count  (busy_count)
    );

    for (genvar g = 0; g < NR_READ; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        logic [DATA_WIDTH-1:0] w_rd;
        logic                  w_hit;

        assign w_ra  = raddr[slice_lo(g, ADDR_WIDTH) +: ADDR_WIDTH];
        assign w_hit = (BYPASS != 0) && wen && (waddr == w_ra);

        // Read mux: reset and x0 force zero, then same-cycle bypass, then array.
        always_comb begin
            w_rd = r_rf[w_ra];
            if (rst) begin
                w_rd = '0;
            end else if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rd = '0;
            end else if (w_hit) begin
                w_rd = w_wdata;
            end
        end

        assign rdata[slice_lo(g, DATA_WIDTH) +: DATA_WIDTH] = w_rd;
        assign rbusy[g] = w_busy[w_ra] && !w_hit;
    end

endmodule

// File: tb/tb_gpr_file_sb.sv
// Directed self-checking bench for gpr_file_sb (default parameters).
module tb_gpr_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [1:0]  wsel;
    logic [31:0] pc, alu_data, mem_data, csr_data;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [5:0]  busy_count;

    int n_checks = 0;
    int n_errors = 0;

    gpr_file_sb dut (
        .clk         (clk),
        .rst         (rst),
        .wen         (wen),
        .waddr       (waddr),
        .wsel        (wsel),
        .pc          (pc),
        .alu_data    (alu_data),
        .mem_data    (mem_data),
        .csr_data    (csr_data),
        .raddr       (raddr),
        .rdata       (rdata),
        .rbusy       (rbusy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .busy_count  (busy_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then step off it before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; waddr = '0; wsel = 2'd0;
        pc = '0; alu_data = '0; mem_data = '0; csr_data = '0;
        raddr = '0; issue_valid = 1'b0; issue_rd = '0;
        tick(); tick();
        check("reset_rdata", rdata, 64'h0);
        check("reset_rbusy", rbusy, 2'b00);
        check("reset_count", busy_count, 6'd0);
        rst = 1'b0;

        // Write sources: pc+4, pc+4 wrap, mem, csr.
        wen = 1'b1; wsel = 2'd1; pc = 32'h8000_0000; waddr = 5'd1; set_rd(5'd1, 5'd2);
        #1 check("pc4_bypass", rdata[31:0], 32'h8000_0004);
        tick();
        pc = 32'hFFFF_FFFC; waddr = 5'd2;
        tick();
        wsel = 2'd2; mem_data = 32'h1234_5678; waddr = 5'd3;
        tick();
        wsel = 2'd3; csr_data = 32'hCAFE_F00D; waddr = 5'd4;
        tick();
        wen = 1'b0;
        set_rd(5'd1, 5'd2);
        #1 check("pc4_stored", rdata[31:0], 32'h8000_0004);
        check("pc4_wrap", rdata[63:32], 32'h0000_0000);
        set_rd(5'd3, 5'd4);
        #1 check("mem_stored", rdata[31:0], 32'h1234_5678);
        check("csr_stored", rdata[63:32], 32'hCAFE_F00D);
        check("no_busy_yet", busy_count, 6'd0);

        // x0: write and issue to index 0 have no effect.
        wen = 1'b1; waddr = 5'd0; wsel = 2'd0; alu_data = 32'hDEAD_BEEF;
        issue_valid = 1'b1; issue_rd = 5'd0; set_rd(5'd0, 5'd0);
        #1 check("x0_bypass_zero", rdata, 64'h0);
        check("x0_rbusy", rbusy, 2'b00);
        tick();
        wen = 1'b0; issue_valid = 1'b0;
        #1 check("x0_stored_zero", rdata[31:0], 32'h0);
        check("x0_count", busy_count, 6'd0);

        // Bypass to both ports reading the same register.
        wen = 1'b1; waddr = 5'd5; alu_data = 32'h11;
        tick();
        alu_data = 32'h22; set_rd(5'd5, 5'd5);
        #1 check("bypass_both", rdata, {32'h22, 32'h22});
        tick();
        wen = 1'b0; alu_data = 32'h33;
        #1 check("bypass_stored", rdata, {32'h22, 32'h22});

        // Scoreboard: issue rd=7, then retire it.
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0; set_rd(5'd7, 5'd5);
        #1 check("sb_count_1", busy_count, 6'd1);
        check("sb_rbusy_7", rbusy, 2'b01);
        wen = 1'b1; waddr = 5'd7; alu_data = 32'h77;
        #1 check("sb_retire_bypass", rbusy, 2'b00);
        check("sb_retire_data", rdata[31:0], 32'h77);
        tick();
        wen = 1'b0;
        #1 check("sb_count_0", busy_count, 6'd0);
        check("sb_rbusy_clear", rbusy, 2'b00);

        // Same-index set and clear keeps the bit.
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        check("sb9_count", busy_count, 6'd1);
        wen = 1'b1; waddr = 5'd9; alu_data = 32'h99;
        tick();
        wen = 1'b0; issue_valid = 1'b0; set_rd(5'd9, 5'd3);
        #1 check("sb9_same_count", busy_count, 6'd1);
        check("sb9_same_busy", rbusy, 2'b01);

        // Move busy from 9 to 3 in one cycle.
        issue_valid = 1'b1; issue_rd = 5'd3; wen = 1'b1; waddr = 5'd9;
        tick();
        issue_valid = 1'b0; wen = 1'b0;
        #1 check("sb_move_count", busy_count, 6'd1);
        check("sb_move_busy", rbusy, 2'b10);

        // Re-issue of busy reg, new issue, and a write to a non-busy reg.
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        check("sb_reissue_count", busy_count, 6'd1);
        issue_rd = 5'd10; wen = 1'b1; waddr = 5'd12; alu_data = 32'hC;
        tick();
        issue_valid = 1'b0; wen = 1'b0; set_rd(5'd10, 5'd12);
        #1 check("sb_two_busy", busy_count, 6'd2);
        check("sb_plain_write", rbusy, 2'b01);
        check("sb_plain_data", rdata[63:32], 32'hC);

        // Asynchronous reset mid-cycle, with a bypassing write present.
        set_rd(5'd1, 5'd3);
        wen = 1'b1; waddr = 5'd1; alu_data = 32'h55;
        #2 rst = 1'b1;
        #1 check("arst_rdata", rdata, 64'h0);
        check("arst_rbusy", rbusy, 2'b00);
        check("arst_count", busy_count, 6'd0);
        tick();
        rst = 1'b0; wen = 1'b0;
        #1 check("arst_after_data", rdata, 64'h0);
        check("arst_after_count", busy_count, 6'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gpr_file_sb.md
Name: gpr_file_sb

Overview:
- Parametrised multi-read-port general-purpose register file for the NPC core, with a write-back source selector and a per-register pending-write scoreboard.
- Read ports are combinational, with optional same-cycle write-to-read bypass.
- The scoreboard tracks registers with an outstanding write (multi-cycle load/CSR), so decode can stall on RAW hazards.
- Sits between decode (read/issue) and write-back (write/retire).

Parameters:
ADDR_WIDTH, 5, register index width
DATA_WIDTH, 32, register width
NR_READ, 2, number of read ports (1..4)
BYPASS, 1, 1 = write data forwarded to matching read port in same cycle
ZERO_REG, 1, 1 = index 0 reads 0, ignores writes, never busy

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
wen  in  1  write-back enable
waddr  in  ADDR_WIDTH  write-back register index
wsel  in  2  write source: 0 alu_data, 1 pc+4, 2 mem_data, 3 csr_data
pc  in  DATA_WIDTH  PC of write-back instruction
alu_data  in  DATA_WIDTH  ALU result
mem_data  in  DATA_WIDTH  load data
csr_data  in  DATA_WIDTH  CSR read value
raddr  in  NR_READ*ADDR_WIDTH  packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
rdata  out  NR_READ*DATA_WIDTH  packed read data
rbusy  out  NR_READ  port i source has pending write not bypassed this cycle
issue_valid  in  1  instruction with destination issued this cycle
issue_rd  in  ADDR_WIDTH  its destination index
busy_count  out  ADDR_WIDTH+1  number of registers currently busy

Behaviour:
- Reset (async, rst=1): all 2^ADDR_WIDTH registers := 0, all busy bits := 0, busy_count := 0. rdata therefore reads 0 and rbusy reads 0 while rst is high. Reset mid-operation discards pending writes and busy state.
- Write data wdata is selected by wsel:
  - 0: alu_data
  - 1: pc+4, truncated to DATA_WIDTH (wraps, e.g. 0xFFFFFFFC -> 0x00000000)
  - 2: mem_data
  - 3: csr_data
- Write: at posedge, if wen && !(ZERO_REG && waddr==0), rf[waddr] <= wdata. Visible on rdata the following cycle (or same cycle via bypass).
- Read: combinational, zero latency.
  - raddr_i==0 with ZERO_REG=1 -> 0.
  - Else BYPASS=1 && wen && waddr==raddr_i -> wdata.
  - Else rf[raddr_i].
  - Multiple ports may address the same register.
- Scoreboard, one busy bit per register, updated at posedge:
  - Set on issue_valid && issue_rd!=0 (or any issue_rd if ZERO_REG=0).
  - Clear on wen && waddr==index.
  - Set and clear of the same index in one cycle: busy stays 1 (new producer wins).
  - Set of an already-busy register: stays 1, no count change.
  - wen to a non-busy register is legal: plain write, busy unchanged.
- rbusy_i = busy[raddr_i] && !(BYPASS && wen && waddr==raddr_i). Index 0 is never busy when ZERO_REG=1.
- busy_count is a registered popcount of busy bits, updated the same edge as the busy bits. Net change per cycle is -1, 0 or +1. Never exceeds 2^ADDR_WIDTH-1 with ZERO_REG=1.
- No X propagation: out-of-range NR_READ is rejected by an elaboration-time assertion.

Decomposition:
- Package npc_rf_pkg:
  - enum wsel_e {WSEL_ALU, WSEL_PC4, WSEL_MEM, WSEL_CSR}.
  - Constant PC_STEP = 4.
  - Function for a packed-slice index helper.
- Sub-module rf_scoreboard:
  - Owns busy bits and busy_count.
  - Inputs: clk, rst, issue_valid, issue_rd, wen, waddr.
  - Output: busy vector.
  - The top level builds rbusy from it.

Test Plan:
- Reset: assert rst mid-run after writes -> all rdata read 0, rbusy=0, busy_count=0, asynchronously before the next edge.
- x0 with ZERO_REG=1: wen, waddr=0, wsel=0, alu_data=0xDEADBEEF, plus issue_rd=0 -> raddr0=0 reads 0, rbusy0=0, busy_count unchanged.
- Write sources: wsel=1, pc=0x80000000, waddr=1 -> next cycle raddr=1 reads 0x80000004; pc=0xFFFFFFFC -> reads 0x00000000; wsel=2 with mem_data=0x12345678 -> 0x12345678.
- Bypass: rf[5]=0x11, same cycle wen waddr=5 alu_data=0x22 with raddr0=raddr1=5 -> both read 0x22 (BYPASS=1) or 0x11 (BYPASS=0).
- Scoreboard: issue rd=7 -> next cycle busy_count=1 and rbusy for raddr=7 is 1. Later wen waddr=7 -> rbusy=0 that cycle (bypass), busy_count=0 next cycle.
- Simultaneous issue rd=9 and wen waddr=9 -> busy stays 1, busy_count unchanged; issue rd=3 and wen waddr=9 in the same cycle -> busy_count unchanged, busy moves from 9 to 3.
